// File: rtl/img_pkg.sv
// Shared constants for the image row scheduler: frame geometry, the fixed-point
// layout of the source row coordinate, slot addressing and FSM encodings.
package img_pkg;

  // Frame geometry
  localparam int OUT_LINES = 1080;
  localparam int IMG_ROWS  = 480;

  // Fixed-point source row: {integer part, fraction}
  localparam int FRAC_W = 5;
  localparam int INT_W  = 10;
  localparam int FIX_W  = INT_W + FRAC_W;

  // 8-row image RAM slot addressing and resident row numbering
  localparam int ID_W  = 3;
  localparam int ROW_W = 9;
  localparam int SLOTS = 8;

  // Counter widths: line counter must reach OUT_LINES, landed counter 0..SLOTS
  localparam int LINE_CNT_W = 11;
  localparam int LANDED_W   = 4;

  // Scheduler states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_H     = 3'd1;
  localparam logic [2:0] ST_EVAL      = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_FLUSH     = 3'd5;

  // Slot following a given slot in the circular 8-row RAM
  function automatic logic [ID_W-1:0] next_slot(input logic [ID_W-1:0] id);
    return ID_W'(id + 1);
  endfunction

endpackage

// File: rtl/img_row_sched_if.sv
// Line command channel between the row scheduler (master) and the bilinear
// vertical interpolator (slave).
interface img_row_sched_if;
  import img_pkg::*;

  logic              line_vld;
  logic              line_ready;
  logic              line_blank;
  logic [ID_W-1:0]   line_id0;
  logic [ID_W-1:0]   line_id1;
  logic [FRAC_W-1:0] line_frac;
  logic              line_done;

  modport master (
    output line_vld,
    output line_blank,
    output line_id0,
    output line_id1,
    output line_frac,
    input  line_ready,
    input  line_done
  );

  modport slave (
    input  line_vld,
    input  line_blank,
    input  line_id0,
    input  line_id1,
    input  line_frac,
    output line_ready,
    output line_done
  );

endinterface

// File: rtl/img_row_sched.sv
// Line scheduler: for every output line it fetches the fixed-point source row,
// waits until the two source rows it blends are resident in the 8-row RAM,
// hands the slot pair and fraction to the interpolator, and releases slots
// only once no later output line can still need them.
module img_row_sched
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              frst,
  input  logic              i_frame_start,
  input  logic [FIX_W-1:0]  i_fix_h,
  input  logic              i_fix_h_vld,
  input  logic              i_fix_h_empty,
  output logic              o_fix_h_re,
  input  logic [ID_W-1:0]   i_8row_id,
  input  logic [ROW_W-1:0]  i_8row_h,
  input  logic              i_8row_empty,
  output logic              o_8row_re,
  input  logic              i_row_wdone,
  img_row_sched_if.master   line_if,
  output logic              o_frame_done,
  output logic              o_err
);

  logic [2:0]            state_q, state_d;
  logic [INT_W-1:0]      h_int_q, h_int_d;
  logic [FRAC_W-1:0]     frac_q, frac_d;
  logic                  vld_q, vld_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [LANDED_W-1:0]   landed_cnt_q, landed_cnt_d;
  logic                  err_q, err_d;
  logic                  line_vld_q, line_vld_d;
  logic                  line_blank_q, line_blank_d;
  logic [ID_W-1:0]       line_id0_q, line_id0_d;
  logic [ID_W-1:0]       line_id1_q, line_id1_d;
  logic [FRAC_W-1:0]     line_frac_q, line_frac_d;
  logic                  frame_done_q, frame_done_d;

  logic                  fix_h_re_raw;
  logic                  row_re_raw;
  logic                  fix_h_re;
  logic                  row_re;
  logic                  flush_clear;
  logic                  issue_err;
  logic                  overflow;
  logic                  need2;
  logic [INT_W-1:0]      head_h;

  // Head row number widened so it compares directly against the integer row
  assign head_h = {{(INT_W-ROW_W){1'b0}}, i_8row_h};

  // The bottom image row has no partner below it and blends with itself
  assign need2 = (h_int_q < INT_W'(IMG_ROWS - 1));

  // FIFO pops are suppressed while reset is held so no entry is lost
  assign fix_h_re = fix_h_re_raw & ~frst;
  assign row_re   = row_re_raw & ~frst;

  // Scheduler FSM: fetch row coordinate, decide release/wait/issue, hand off, flush
  always_comb begin
    state_d      = state_q;
    h_int_d      = h_int_q;
    frac_d       = frac_q;
    vld_d        = vld_q;
    line_cnt_d   = line_cnt_q;
    line_vld_d   = line_vld_q;
    line_blank_d = line_blank_q;
    line_id0_d   = line_id0_q;
    line_id1_d   = line_id1_q;
    line_frac_d  = line_frac_q;
    frame_done_d = 1'b0;
    fix_h_re_raw = 1'b0;
    row_re_raw   = 1'b0;
    flush_clear  = 1'b0;
    issue_err    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_frame_start) begin
          state_d = ST_GET_H;
        end
      end

      ST_GET_H: begin
        if (!i_fix_h_empty) begin
          fix_h_re_raw = 1'b1;
          h_int_d      = i_fix_h[FIX_W-1:FRAC_W];
          frac_d       = i_fix_h[FRAC_W-1:0];
          vld_d        = i_fix_h_vld;
          state_d      = ST_EVAL;
        end
      end

      ST_EVAL: begin
        if (!vld_q) begin
          line_vld_d   = 1'b1;
          line_blank_d = 1'b1;
          line_id0_d   = '0;
          line_id1_d   = '0;
          line_frac_d  = '0;
          state_d      = ST_ISSUE;
        end else if (i_8row_empty || (landed_cnt_q == '0)) begin
          state_d = ST_EVAL;
        end else if (head_h < h_int_q) begin
          row_re_raw = 1'b1;
        end else if (need2 && (landed_cnt_q < LANDED_W'(2))) begin
          state_d = ST_EVAL;
        end else begin
          line_vld_d   = 1'b1;
          line_blank_d = 1'b0;
          line_id0_d   = i_8row_id;
          line_id1_d   = need2 ? next_slot(i_8row_id) : i_8row_id;
          line_frac_d  = need2 ? frac_q : '0;
          issue_err    = (head_h > h_int_q);
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (line_if.line_ready) begin
          line_vld_d = 1'b0;
          state_d    = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (line_if.line_done) begin
          line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
          if (line_cnt_q == LINE_CNT_W'(OUT_LINES - 1)) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_GET_H;
          end
        end
      end

      ST_FLUSH: begin
        if (!i_8row_empty) begin
          row_re_raw = 1'b1;
        end else begin
          flush_clear  = 1'b1;
          line_cnt_d   = '0;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Resident-row bookkeeping and sticky protocol error
  always_comb begin
    landed_cnt_d = landed_cnt_q;
    overflow     = i_row_wdone && !row_re && (landed_cnt_q == LANDED_W'(SLOTS));

    if (flush_clear) begin
      landed_cnt_d = '0;
    end else if (i_row_wdone && !row_re) begin
      if (!overflow) begin
        landed_cnt_d = landed_cnt_q + LANDED_W'(1);
      end
    end else if (!i_row_wdone && row_re && (landed_cnt_q != '0)) begin
      landed_cnt_d = landed_cnt_q - LANDED_W'(1);
    end

    err_d = err_q | issue_err | overflow;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (frst) begin
      state_q      <= ST_IDLE;
      h_int_q      <= '0;
      frac_q       <= '0;
      vld_q        <= 1'b0;
      line_cnt_q   <= '0;
      landed_cnt_q <= '0;
      err_q        <= 1'b0;
      line_vld_q   <= 1'b0;
      line_blank_q <= 1'b0;
      line_id0_q   <= '0;
      line_id1_q   <= '0;
      line_frac_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_int_q      <= h_int_d;
      frac_q       <= frac_d;
      vld_q        <= vld_d;
      line_cnt_q   <= line_cnt_d;
      landed_cnt_q <= landed_cnt_d;
      err_q        <= err_d;
      line_vld_q   <= line_vld_d;
      line_blank_q <= line_blank_d;
      line_id0_q   <= line_id0_d;
      line_id1_q   <= line_id1_d;
      line_frac_q  <= line_frac_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_fix_h_re         = fix_h_re;
  assign o_8row_re          = row_re;
  assign line_if.line_vld   = line_vld_q;
  assign line_if.line_blank = line_blank_q;
  assign line_if.line_id0   = line_id0_q;
  assign line_if.line_id1   = line_id1_q;
  assign line_if.line_frac  = line_frac_q;
  assign o_frame_done       = frame_done_q;
  assign o_err              = err_q;

endmodule

// File: tb/tb_img_row_sched.sv
// Self-checking bench for img_row_sched: models the fix_h and 8row FIFOs, the
// row writer and the interpolator, and scores every line command against a
// queue of expected commands pushed when each line's row coordinate is queued.
module tb_img_row_sched;
  import img_pkg::*;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [ROW_W-1:0] h;
  } row_t;

  typedef struct packed {
    logic              blank;
    logic [ID_W-1:0]   id0;
    logic [ID_W-1:0]   id1;
    logic [FRAC_W-1:0] frac;
  } cmd_t;

  logic             clk = 1'b0;
  logic             frst = 1'b1;
  logic             i_frame_start = 1'b0;
  logic [FIX_W-1:0] i_fix_h = '0;
  logic             i_fix_h_vld = 1'b0;
  logic             i_fix_h_empty = 1'b1;
  logic             o_fix_h_re;
  logic [ID_W-1:0]  i_8row_id = '0;
  logic [ROW_W-1:0] i_8row_h = '0;
  logic             i_8row_empty = 1'b1;
  logic             o_8row_re;
  logic             i_row_wdone = 1'b0;
  logic             o_frame_done;
  logic             o_err;

  img_row_sched_if line_if();

  img_row_sched dut (
    .clk           (clk),
    .frst          (frst),
    .i_frame_start (i_frame_start),
    .i_fix_h       (i_fix_h),
    .i_fix_h_vld   (i_fix_h_vld),
    .i_fix_h_empty (i_fix_h_empty),
    .o_fix_h_re    (o_fix_h_re),
    .i_8row_id     (i_8row_id),
    .i_8row_h      (i_8row_h),
    .i_8row_empty  (i_8row_empty),
    .o_8row_re     (o_8row_re),
    .i_row_wdone   (i_row_wdone),
    .line_if       (line_if.master),
    .o_frame_done  (o_frame_done),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  int   n_compared = 0;
  int   n_mismatched = 0;

  row_t        rowq[$];
  row_t        land_q[$];
  logic [15:0] fixq[$];
  cmd_t        expq[$];
  int          pop_cyc[$];

  int   cyc = 0;
  int   pop_cnt = 0;
  int   cmd_cnt = 0;
  int   lines_done = 0;
  int   fd_cnt = 0;
  int   viol_row = 0;
  int   viol_fix = 0;
  int   model_landed = 0;
  int   done_cnt = 0;
  int   hold_cnt = 0;
  int   held_seen = 0;
  bit   fs_pend = 0;
  bit   land_on_pop = 0;
  bit   pend_pop = 0;
  bit   pend_fix = 0;
  bit   pend_wdone = 0;
  cmd_t snap;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifos();
    logic [15:0] f;
    i_8row_empty = (rowq.size() == 0);
    if (rowq.size() > 0) begin
      i_8row_id = rowq[0].id;
      i_8row_h  = rowq[0].h;
    end else begin
      i_8row_id = '0;
      i_8row_h  = '0;
    end
    i_fix_h_empty = (fixq.size() == 0);
    if (fixq.size() > 0) begin
      f           = fixq[0];
      i_fix_h     = f[14:0];
      i_fix_h_vld = f[15];
    end else begin
      i_fix_h     = '0;
      i_fix_h_vld = 1'b0;
    end
  endtask

  // One clock of environment: retire last cycle's pops, drive inputs, observe
  task automatic applyStimulus();
    cmd_t cur;
    cmd_t e;
    @(negedge clk);
    cyc++;
    if (pend_pop && rowq.size() > 0) rowq.delete(0);
    if (pend_fix && fixq.size() > 0) fixq.delete(0);
    if (pend_wdone && !pend_pop) begin
      if (model_landed < SLOTS) model_landed++;
    end else if (!pend_wdone && pend_pop && model_landed > 0) begin
      model_landed--;
    end
    pend_pop   = 0;
    pend_fix   = 0;
    pend_wdone = 0;

    i_frame_start = fs_pend;
    fs_pend       = 0;
    i_row_wdone   = 1'b0;
    if (land_q.size() > 0 && !land_on_pop) begin
      rowq.push_back(land_q.pop_front());
      i_row_wdone = 1'b1;
    end
    line_if.line_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        line_if.line_done = 1'b1;
        lines_done++;
      end
    end
    line_if.line_ready = (hold_cnt == 0);
    drive_fifos();

    #1;
    if (o_8row_re === 1'b1 && land_on_pop && land_q.size() > 0) begin
      rowq.push_back(land_q.pop_front());
      i_row_wdone = 1'b1;
      land_on_pop = 0;
    end
    pend_wdone = i_row_wdone;
    if (o_8row_re === 1'b1) begin
      pend_pop = 1;
      pop_cnt++;
      pop_cyc.push_back(cyc);
      if (i_8row_empty) viol_row++;
    end
    if (o_fix_h_re === 1'b1) begin
      pend_fix = 1;
      if (i_fix_h_empty) viol_fix++;
    end
    if (o_frame_done === 1'b1) fd_cnt++;

    cur = {line_if.line_blank, line_if.line_id0, line_if.line_id1, line_if.line_frac};
    if (line_if.line_vld === 1'b1 && line_if.line_ready === 1'b1) begin
      cmd_cnt++;
      checkOutput($sformatf("cmd%0d_pending", cmd_cnt), 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput($sformatf("cmd%0d", cmd_cnt), 32'(cur), 32'(e));
      end
      done_cnt = 2;
    end else if (line_if.line_vld === 1'b1 && hold_cnt > 0) begin
      if (held_seen == 0) snap = cur;
      else checkOutput("held_stable", 32'(cur), 32'(snap));
      held_seen++;
      hold_cnt--;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic land_row(input int id, input int h);
    row_t r;
    r.id = ID_W'(id);
    r.h  = ROW_W'(h);
    land_q.push_back(r);
  endtask

  task automatic push_line(input bit vld, input int rowInt, input int frac,
                           input bit eb, input int e0, input int e1, input int ef);
    cmd_t c;
    fixq.push_back({vld, INT_W'(rowInt), FRAC_W'(frac)});
    c.blank = eb;
    c.id0   = ID_W'(e0);
    c.id1   = ID_W'(e1);
    c.frac  = FRAC_W'(ef);
    expq.push_back(c);
  endtask

  task automatic wait_cmds(input int n, input int budget);
    int k = 0;
    while (cmd_cnt < n && k < budget) begin
      applyStimulus();
      k++;
    end
    if (cmd_cnt < n) checkOutput("cmd_timeout", 32'(cmd_cnt), 32'(n));
  endtask

  task automatic wait_lines(input int n, input int budget);
    int k = 0;
    while (lines_done < n && k < budget) begin
      applyStimulus();
      k++;
    end
    if (lines_done < n) checkOutput("line_done_timeout", 32'(lines_done), 32'(n));
  endtask

  initial begin
    int pops0;
    int k;

    line_if.line_ready = 1'b1;
    line_if.line_done  = 1'b0;

    // Reset state
    frst = 1'b1;
    ticks(3);
    checkOutput("reset_outs",
      32'({o_fix_h_re, o_8row_re, line_if.line_vld, line_if.line_blank, line_if.line_id0,
           line_if.line_id1, line_if.line_frac, o_frame_done, o_err}), 32'd0);
    frst = 1'b0;
    ticks(2);

    // Blank line with the row FIFO empty: no pops
    $display("[TB] frame start, blank line");
    fs_pend = 1;
    pops0 = pop_cnt;
    push_line(0, 12'h123, 5, 1, 0, 0, 0);
    wait_cmds(1, 50);
    wait_lines(1, 50);
    checkOutput("blank_no_pop", 32'(pop_cnt - pops0), 32'd0);

    // h = 0.5 with rows 0,1 resident in slots 0,1
    land_row(0, 0);
    land_row(1, 1);
    ticks(3);
    pops0 = pop_cnt;
    push_line(1, 0, 16, 0, 0, 1, 16);
    wait_cmds(2, 50);
    wait_lines(2, 50);
    checkOutput("l1_no_pop", 32'(pop_cnt - pops0), 32'd0);
    checkOutput("l1_landed", 32'(dut.landed_cnt_q), 32'(model_landed));

    // h int 2 with head at row 0: two back-to-back releases, a write landing on the first
    land_row(2, 2);
    land_row(3, 3);
    ticks(3);
    land_on_pop = 1;
    land_row(4, 4);
    pops0 = pop_cnt;
    pop_cyc.delete();
    push_line(1, 2, 7, 0, 2, 3, 7);
    wait_cmds(3, 50);
    checkOutput("l2_pops", 32'(pop_cnt - pops0), 32'd2);
    if (pop_cyc.size() >= 2)
      checkOutput("l2_pops_consecutive", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    wait_lines(3, 50);
    checkOutput("l2_landed", 32'(dut.landed_cnt_q), 32'd3);

    // Same rows again with the interpolator stalling for 5 cycles
    hold_cnt  = 5;
    held_seen = 0;
    pops0 = pop_cnt;
    push_line(1, 2, 9, 0, 2, 3, 9);
    wait_cmds(4, 50);
    wait_lines(4, 50);
    checkOutput("hold_cycles", 32'(held_seen), 32'd5);
    checkOutput("l3_no_pop", 32'(pop_cnt - pops0), 32'd0);

    // h int 4: two releases, then wait for the second row to land
    pops0 = pop_cnt;
    push_line(1, 4, 1, 0, 4, 5, 1);
    ticks(8);
    checkOutput("l4_waits_for_row", 32'(line_if.line_vld), 32'd0);
    checkOutput("l4_no_early_cmd", 32'(cmd_cnt), 32'd4);
    land_row(5, 5);
    wait_cmds(5, 50);
    wait_lines(5, 50);
    checkOutput("l4_pops", 32'(pop_cnt - pops0), 32'd2);
    checkOutput("l4_landed", 32'(dut.landed_cnt_q), 32'd2);

    // Bottom row: single resident row, fraction forced to 0
    pops0 = pop_cnt;
    push_line(1, 479, 20, 0, 6, 6, 0);
    ticks(6);
    land_row(6, 479);
    wait_cmds(6, 50);
    wait_lines(6, 50);
    checkOutput("bottom_pops", 32'(pop_cnt - pops0), 32'd2);
    checkOutput("bottom_landed", 32'(dut.landed_cnt_q), 32'd1);

    // Fill the rest of the frame with blank lines, 3 rows resident for the flush
    land_row(7, 480);
    land_row(0, 481);
    ticks(3);
    pops0 = pop_cnt;
    for (int i = 6; i < OUT_LINES; i++) push_line(0, 0, 0, 1, 0, 0, 0);
    wait_cmds(OUT_LINES, 20000);
    wait_lines(OUT_LINES, 200);
    k = 0;
    while (fd_cnt == 0 && k < 50) begin
      applyStimulus();
      k++;
    end
    ticks(4);
    checkOutput("frame_done_pulses", 32'(fd_cnt), 32'd1);
    checkOutput("flush_pops", 32'(pop_cnt - pops0), 32'd3);
    checkOutput("flush_fifo_empty", 32'(rowq.size()), 32'd0);
    checkOutput("flush_landed", 32'(dut.landed_cnt_q), 32'd0);
    checkOutput("err_clear", 32'(o_err), 32'd0);

    // Back in IDLE: a queued row coordinate is left alone
    fixq.push_back(16'h8040);
    ticks(6);
    checkOutput("idle_no_fix_pop", 32'(fixq.size()), 32'd1);
    fixq.delete();

    // Nine writes into eight slots
    for (int i = 0; i < 8; i++) land_row(i, i);
    ticks(10);
    checkOutput("landed_full", 32'(dut.landed_cnt_q), 32'd8);
    checkOutput("err_before_ovf", 32'(o_err), 32'd0);
    land_row(0, 8);
    ticks(3);
    checkOutput("err_after_ovf", 32'(o_err), 32'd1);
    checkOutput("landed_saturate", 32'(dut.landed_cnt_q), 32'(model_landed));

    // Reset in the middle of a stalled command
    fs_pend   = 1;
    hold_cnt  = 50;
    held_seen = 0;
    fixq.push_back(16'h0000);
    k = 0;
    while (line_if.line_vld !== 1'b1 && k < 20) begin
      applyStimulus();
      k++;
    end
    checkOutput("abandon_cmd_seen", 32'(line_if.line_vld), 32'd1);
    frst = 1'b1;
    applyStimulus();
    checkOutput("reset_abandon", 32'({line_if.line_vld, o_err}), 32'd0);
    frst     = 1'b0;
    hold_cnt = 0;
    ticks(2);

    checkOutput("row_re_when_empty", 32'(viol_row), 32'd0);
    checkOutput("fix_re_when_empty", 32'(viol_fix), 32'd0);
    checkOutput("all_cmds_seen", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
